// File: rtl/count_sched_pkg.sv
// count_sched_pkg
// Shared definitions for the delay scheduler and its counter datapath:
//   - state_t      : scheduler FSM encoding (IDLE/LOAD/RUN/DONE)
//   - DEF_WIDTH    : default counter/delay width
//   - TERM_COUNT   : terminal count for the default width (all ones)
//   - REQ_0/REQ_1  : requester index constants used for owner/rr pointer
package count_sched_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [DEF_WIDTH-1:0] TERM_COUNT = {DEF_WIDTH{1'b1}};

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/count_sched_dp.sv
// count_dp
// WIDTH-bit loadable up-counter. Load has priority over EN.
// Ports:
//   clk    in   rising-edge clock
//   res    in   asynchronous active-low reset (clears CNT)
//   EN     in   count enable (increment by one)
//   load   in   synchronous load of CNT_In
//   CNT_In in   load value
//   CNT    out  current count
module count_dp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic [WIDTH-1:0] CNT_In,
    output logic [WIDTH-1:0] CNT
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            CNT <= '0;
        end else if (load) begin
            CNT <= CNT_In;
        end else if (EN) begin
            CNT <= CNT + ONE;
        end
    end

endmodule

// File: rtl/count_sched.sv
// count_sched
// Shares one WIDTH-bit up-counter between two requesters. The winner's
// delay N is latched, the counter is loaded with ~N and counts up to all
// ones, taking exactly N increments, then done is pulsed to the owner.
//
// Handshake: reqX is a level held by the requester until it sees the
// one-cycle gntX pulse; dlyX is sampled on the granting edge only. doneX
// is a one-cycle pulse when the delay has expired. Requests are only
// looked at while the scheduler is IDLE.
//
// Ports:
//   clk          in   rising-edge clock
//   res          in   asynchronous active-low reset
//   req0/req1    in   delay requests (level)
//   dly0/dly1    in   requested delay in cycles
//   gnt0/gnt1    out  grant pulses
//   done0/done1  out  delay-expired pulses
//   busy         out  high whenever the FSM is not IDLE
//   CNT          out  live counter value
//   state        out  FSM state (state_t encoding) for observation
module count_sched
    import count_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req0,
    input  logic [WIDTH-1:0] dly0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dly1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] CNT,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] TERM = {WIDTH{1'b1}};

    state_t           st;
    logic             owner;
    logic             rr;
    logic [WIDTH-1:0] target;

    logic             grant_any;
    logic             grant_id;
    logic             dp_load;
    logic             dp_en;
    logic [WIDTH-1:0] dp_in;

    assign state = st;

    // Round-robin: on contention the requester that did not win last
    // time is picked. rr resets to 1 so requester 0 wins the first tie.
    always_comb begin
        grant_any = req0 | req1;
        grant_id  = REQ_0;
        if (req0 && req1) begin
            grant_id = ~rr;
        end else if (req1) begin
            grant_id = REQ_1;
        end
    end

    // Loading ~N means exactly N increments are needed to reach all ones.
    assign dp_load = (st == ST_LOAD);
    assign dp_in   = ~target;
    assign dp_en   = (st == ST_RUN) && (CNT != TERM);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            st     <= ST_IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            busy   <= 1'b0;
            owner  <= REQ_0;
            rr     <= REQ_1;
            target <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner  <= grant_id;
                        rr     <= grant_id;
                        target <= (grant_id == REQ_1) ? dly1 : dly0;
                        gnt0   <= (grant_id == REQ_0);
                        gnt1   <= (grant_id == REQ_1);
                        busy   <= 1'b1;
                        st     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    st <= ST_RUN;
                end
                ST_RUN: begin
                    // Leave RUN on the edge after the counter settled at all ones.
                    if (CNT == TERM) begin
                        done0 <= (owner == REQ_0);
                        done1 <= (owner == REQ_1);
                        st    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    st   <= ST_IDLE;
                end
            endcase
        end
    end

    count_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .res    (res),
        .EN     (dp_en),
        .load   (dp_load),
        .CNT_In (dp_in),
        .CNT    (CNT)
    );

endmodule
